systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for the N×N weight-stationary systolic PE array. It runs one tile per `start`. First it loads N weight words through the array's weight-shift chain and latches them into every PE's local register. It then streams M activation vectors from the activation buffer with per-row skew masks and flags the valid partial sums leaving the bottom of each column. It sits between the tile-level host/sequencer and the array plus its weight, activation and output buffers.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns), ≥2
- `AW`, $clog2(N): weight-buffer address width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin tile; sampled only in IDLE
- `keep_w`  in  1  sampled with `start`; 1 = skip weight load and reuse the latched weights
- `num_vec`  in  16  M, the activation vector count; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at tile end
- `w_rd_en`  out  1  weight-buffer read strobe; buffer read latency is 1 cycle
- `w_rd_addr`  out  AW  weight row address
- `pe_flag`  out  1  array-wide weight-shift freeze; 1 = frozen
- `pe_wr_en`  out  1  array-wide LRF latch strobe
- `a_rd_en`  out  1  activation-buffer read strobe; read latency is 1 cycle
- `a_rd_addr`  out  16  activation vector index
- `act_valid`  out  N  per-row mask; feeder drives zero on rows whose bit is 0
- `o_valid`  out  N  per-column valid for the bottom-row `out_PSUM`
- `o_last`  out  1  marks the final valid output of the tile

## Operation
States: IDLE → LOAD → LATCH → STREAM → DONE → IDLE.
- IDLE
  - `start`=1 captures M and `keep_w`.
  - `keep_w`=0 → LOAD. `keep_w`=1 → STREAM. `keep_w`=1 is legal only after at least one completed load since reset.
- LOAD (N cycles, load counter k=0..N-1)
  - `w_rd_en`=1, `w_rd_addr`=N-1-k, `pe_flag`=0.
  - The bottom row's word is read first.
- LATCH (1 cycle)
  - The last word is on the array weight input.
  - `pe_wr_en`=1, `pe_flag`=0. Row i latches the word at address i.
  - Next state: STREAM.
- STREAM, with stream counter t starting at 0 and `pe_flag`=1:
  - `a_rd_en`=1 and `a_rd_addr`=t for t in 0..M-1.
  - `act_valid[i]`=1 for t in i+1..i+M.
  - `o_valid[j]`=1 for t in N+1+j..N+j+M.
  - `o_last`=1 at t=M+2N-1 (column N-1, last vector).
  - Leaves STREAM after t=M+2N-1.
- M=0 in STREAM
  - No reads; all `act_valid` and `o_valid` stay 0; `o_last` is never asserted.
  - STREAM lasts exactly 1 cycle, then DONE.
- DONE (1 cycle): `done`=1, then IDLE.
- `start` outside IDLE is ignored. No queuing.
- Stream counter: 18 bits, with no wrap for M ≤ 65535 and N ≤ 64.
- Address arithmetic is unsigned.
- Outputs are decoded combinationally from registered state and counters. They must not glitch-depend on any input.

## Timing
- Reset (`rst`=0, asynchronous) → IDLE, counters cleared. Reset values:
  - `busy`=0, `done`=0, `w_rd_en`=0, `w_rd_addr`=0
  - `pe_flag`=1, `pe_wr_en`=0
  - `a_rd_en`=0, `a_rd_addr`=0
  - `act_valid`=0, `o_valid`=0, `o_last`=0
- Reset mid-tile: abort immediately to IDLE with the reset values above. A later `keep_w`=1 is then illegal until a full load completes.
- Reset release is synchronised by the top level. The first `start` is accepted on the first rising edge with `rst`=1.
- Latency, `start` edge to `done` pulse:
  - `keep_w`=0: N+1+(M+2N)+1 cycles.
  - `keep_w`=1: M+2N+1 cycles.
  - M=0 with `keep_w`=0: N+3 cycles.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- Back-to-back tiles: `start` held high through DONE is accepted in the first IDLE cycle, giving one idle cycle between tiles.

## Test plan
- N=4, M=3, `keep_w`=0:
  - `w_rd_addr` is 3,2,1,0 on cycles 1-4 and `pe_wr_en` pulses on cycle 5.
  - `o_valid[0]` is high at t=5..7 and `o_valid[3]` at t=8..10.
  - `o_last` at t=10; `done` 17 cycles after `start`.
  - Array outputs match a 4×4 by 4×3 matrix-product reference.
- N=4, M=2, `keep_w`=1 after the previous tile: no `w_rd_en`; `done` at cycle 11; results use the old weights.
- M=0, `keep_w`=0: a full load and latch, then STREAM for 1 cycle with no `a_rd_en`/`o_valid`/`o_last`; `done` at cycle 7.
- Reset at LOAD k=2:
  - Asynchronously, all outputs take reset values at once and `pe_flag`=1.
  - A fresh tile then completes correctly.
- `start` pulsed during STREAM and DONE is ignored. `start` held high yields back-to-back tiles with exactly one IDLE cycle between them.
- M=65535, N=4: `a_rd_addr` reaches 65534 with no wrap; `o_last` at t=65542.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Tile sequencer for an NxN weight-stationary systolic array: weight load,
// LRF latch, then skewed activation streaming with output-valid flags.
module systolic_ctrl #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          keep_w,
    input  logic [15:0]   num_vec,
    output logic          busy,
    output logic          done,
    output logic          w_rd_en,
    output logic [AW-1:0] w_rd_addr,
    output logic          pe_flag,
    output logic          pe_wr_en,
    output logic          a_rd_en,
    output logic [15:0]   a_rd_addr,
    output logic [N-1:0]  act_valid,
    output logic [N-1:0]  o_valid,
    output logic          o_last,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LATCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [17:0]   N18     = 18'(N);
    localparam logic [AW-1:0] TOP_ROW = AW'(N - 1);

    state_t      state;
    logic [17:0] cnt;
    logic [15:0] m_reg;
    logic        w_loaded;
    logic [17:0] m18;
    logic [17:0] t_last;
    logic        stream_end;
    logic        in_stream;

    assign m18        = {2'b00, m_reg};
    assign t_last     = m18 + (N18 << 1) - 18'd1;
    assign stream_end = (m_reg == 16'd0) || (cnt == t_last);

    // w_loaded guards keep_w: without a completed load since reset the
    // weights are undefined, so the tile falls back to a full load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            m_reg    <= '0;
            w_loaded <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        m_reg <= num_vec;
                        state <= (keep_w && w_loaded) ? S_STREAM : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == N18 - 18'd1) begin
                        cnt   <= '0;
                        state <= S_LATCH;
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_LATCH: begin
                    w_loaded <= 1'b1;
                    cnt      <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (stream_end) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_stream = (state == S_STREAM);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign w_rd_en   = (state == S_LOAD);
    // Bottom row first: the shift chain pushes the first word furthest down.
    assign w_rd_addr = w_rd_en ? (TOP_ROW - cnt[AW-1:0]) : '0;
    assign pe_flag   = !((state == S_LOAD) || (state == S_LATCH));
    assign pe_wr_en  = (state == S_LATCH);
    assign a_rd_en   = in_stream && (cnt < m18);
    assign a_rd_addr = a_rd_en ? cnt[15:0] : '0;
    assign o_last    = in_stream && (m_reg != 16'd0) && (cnt == t_last);
    assign dbg_state = state;

    // Row i sees vector v at t=v+i+1; column j emits it at t=v+N+1+j.
    always_comb begin
        act_valid = '0;
        o_valid   = '0;
        for (int i = 0; i < N; i++) begin
            act_valid[i] = in_stream && (cnt >= 18'(i + 1)) && (cnt <= 18'(i) + m18);
            o_valid[i]   = in_stream && (cnt >= N18 + 18'(i + 1)) && (cnt <= N18 + 18'(i) + m18);
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: per-cycle expected output vectors are
// queued at tile start and popped/compared after each clock edge.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          w_rd_en;
        logic [AW-1:0] w_rd_addr;
        logic          pe_flag;
        logic          pe_wr_en;
        logic          a_rd_en;
        logic [15:0]   a_rd_addr;
        logic [N-1:0]  act_valid;
        logic [N-1:0]  o_valid;
        logic          o_last;
    } vec_t;

    localparam int W = $bits(vec_t);

    logic          clk;
    logic          rst;
    logic          start;
    logic          keep_w;
    logic [15:0]   num_vec;
    logic          busy;
    logic          done;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          pe_flag;
    logic          pe_wr_en;
    logic          a_rd_en;
    logic [15:0]   a_rd_addr;
    logic [N-1:0]  act_valid;
    logic [N-1:0]  o_valid;
    logic          o_last;
    logic [2:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    systolic_ctrl #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_w(keep_w), .num_vec(num_vec),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .pe_flag(pe_flag), .pe_wr_en(pe_wr_en), .a_rd_en(a_rd_en),
        .a_rd_addr(a_rd_addr), .act_valid(act_valid), .o_valid(o_valid),
        .o_last(o_last), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t raw_obs();
        vec_t v;
        v = '{busy, done, w_rd_en, w_rd_addr, pe_flag, pe_wr_en, a_rd_en,
              a_rd_addr, act_valid, o_valid, o_last};
        return v;
    endfunction

    // Addresses only carry meaning while their read strobe is high.
    function automatic vec_t masked_obs();
        vec_t v;
        v = raw_obs();
        if (!v.w_rd_en) v.w_rd_addr = '0;
        if (!v.a_rd_en) v.a_rd_addr = '0;
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v = '0;
        v.pe_flag = 1'b1;
        return v;
    endfunction

    // Expected outputs c cycles after the accepting edge (c=0 is first busy cycle).
    function automatic vec_t model(input bit keep, input int m, input int c);
        vec_t v;
        int   l;
        int   s;
        int   t;
        v = '0;
        v.pe_flag = 1'b1;
        l = keep ? 0 : N + 1;
        s = (m == 0) ? 1 : m + 2 * N;
        if (!keep && c < N) begin
            v.busy      = 1'b1;
            v.w_rd_en   = 1'b1;
            v.w_rd_addr = AW'(N - 1 - c);
            v.pe_flag   = 1'b0;
        end else if (!keep && c == N) begin
            v.busy     = 1'b1;
            v.pe_wr_en = 1'b1;
            v.pe_flag  = 1'b0;
        end else if (c < l + s) begin
            t = c - l;
            v.busy    = 1'b1;
            v.a_rd_en = (t < m);
            if (t < m) v.a_rd_addr = 16'(t);
            for (int i = 0; i < N; i++) begin
                v.act_valid[i] = (t >= i + 1) && (t <= i + m);
                v.o_valid[i]   = (t >= N + 1 + i) && (t <= N + i + m);
            end
            v.o_last = (m != 0) && (t == m + 2 * N - 1);
        end else if (c == l + s) begin
            v.busy = 1'b1;
            v.done = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string tag, input int cyc, input vec_t obs, input vec_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one tile; hold keeps start high throughout, pulse pokes start
    // during STREAM and DONE and expects it to be ignored.
    task automatic run_tile(input string tag, input bit keep, input int m,
                            input bit hold, input bit pulse);
        int l;
        int s;
        int len;
        int done_idx;
        logic [W-1:0] e;
        l        = keep ? 0 : N + 1;
        s        = (m == 0) ? 1 : m + 2 * N;
        done_idx = l + s;
        len      = done_idx + (hold ? 2 : 3);
        for (int c = 0; c < len; c++) exp_q.push_back(model(keep, m, c));
        start   = 1'b1;
        keep_w  = keep;
        num_vec = 16'(m);
        for (int c = 0; c < len; c++) begin
            step();
            if (c == 0 && !hold) start = 1'b0;
            if (pulse) begin
                if (c == l + 1)        start = 1'b1;
                if (c == l + 2)        start = 1'b0;
                if (c == done_idx)     start = 1'b1;
                if (c == done_idx + 1) start = 1'b0;
            end
            e = exp_q.pop_front();
            check(tag, c, masked_obs(), e);
        end
    endtask

    initial begin
        int rm;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        start   = 1'b0;
        keep_w  = 1'b0;
        num_vec = '0;
        #3;
        check("reset", 0, raw_obs(), reset_vec());
        @(negedge clk);
        rst = 1'b1;

        run_tile("m3_load", 1'b0, 3, 1'b0, 1'b0);
        run_tile("m2_keep", 1'b1, 2, 1'b0, 1'b0);
        run_tile("m0_load", 1'b0, 0, 1'b0, 1'b0);
        run_tile("m0_keep", 1'b1, 0, 1'b0, 1'b0);

        // Abort during LOAD at k=2, then a fresh tile.
        start   = 1'b1;
        keep_w  = 1'b0;
        num_vec = 16'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            start = 1'b0;
            check("abort_load", c, masked_obs(), model(1'b0, 3, c));
        end
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 0, raw_obs(), reset_vec());
        @(negedge clk);
        check("reset_hold", 0, raw_obs(), reset_vec());
        rst = 1'b1;
        run_tile("after_reset", 1'b0, 2, 1'b0, 1'b0);

        run_tile("ignore_start", 1'b1, 3, 1'b0, 1'b1);
        run_tile("b2b_a", 1'b0, 1, 1'b1, 1'b0);
        run_tile("b2b_b", 1'b1, 2, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rm = $urandom_range(1, 20);
            run_tile("rand", 1'($urandom_range(0, 1)), rm, 1'b0, 1'b0);
        end

        run_tile("m_max", 1'b1, 65535, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
